seq_detector_param: RTL and testbench

- Parametrised serial pattern detector; successor to the fixed 3-bit "101" detector.
- Samples one serial bit per enabled clock and compares the last PAT_LEN bits against a run-time loadable pattern.
- Supports overlapping and non-overlapping match modes, and pulses a one-cycle match flag.
- Keeps a saturating match counter; sits on the serial input path ahead of framing/control logic.

---
 rtl/seq_detector_param.sv | 118 +++++++++++
 tb/tb_seq_detector_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//   Parametrised serial pattern detector. It samples one bit of `aa` on every
//   rising edge with en=1 and compares the most recent PAT_LEN bits against a
//   pattern register that can be reloaded at run time. A match produces a
//   one-cycle registered pulse on `ww` and bumps a saturating match counter.
//
// Parameters
//   PAT_LEN  : pattern length in bits (2..16)
//   PAT_INIT : pattern loaded at reset; the MSB is the first-received bit
//   OVERLAP  : 1 = overlapping matches count, 0 = a match consumes its bits
//   CNT_W    : width of the match counter
//
// Ports
//   clock     : system clock, rising edge active
//   rst       : asynchronous active-low reset
//   en        : sample enable for aa
//   aa        : serial data bit
//   pat_load  : load pat_in into the pattern register (wins over en)
//   pat_in    : new pattern value
//   cnt_clr   : synchronous clear of match_cnt (wins over a hit)
//   ww        : registered one-cycle match pulse
//   pattern   : current pattern register
//   match_cnt : saturating match count
// ---------------------------------------------------------------------------
module seq_detector_param #(
  parameter int unsigned          PAT_LEN  = 3,
  parameter logic [PAT_LEN-1:0]   PAT_INIT = PAT_LEN'(3'b101),
  parameter bit                   OVERLAP  = 1'b1,
  parameter int unsigned          CNT_W    = 8
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               en,
  input  logic               aa,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               ww,
  output logic [PAT_LEN-1:0] pattern,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  // Elaboration-time guard on the supported configuration range.
  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("seq_detector_param: PAT_LEN must be in 2..16");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be at least 1");
  end

  // Shift history and the number of valid bits it currently holds.
  logic [PAT_LEN-1:0] shreg;
  logic [FILL_W-1:0]  fill;

  logic               sample_c;
  logic [PAT_LEN-1:0] shreg_shift_c;
  logic [FILL_W-1:0]  fill_inc_c;
  logic               hit_c;

  // Next-sample view of the history; a hit needs a full window, which keeps
  // the reset zeros from matching an all-zeros pattern.
  always_comb begin
    sample_c      = en && !pat_load;
    shreg_shift_c = {shreg[PAT_LEN-2:0], aa};
    fill_inc_c    = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    hit_c         = sample_c && (fill_inc_c == FILL_FULL) &&
                    (shreg_shift_c == pattern);
  end

  // History and pattern registers; a load discards both history and the
  // bit presented on that edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      fill    <= '0;
      pattern <= PAT_INIT;
    end else if (pat_load) begin
      shreg   <= '0;
      fill    <= '0;
      pattern <= pat_in;
    end else if (en) begin
      shreg <= shreg_shift_c;
      // Non-overlapping mode restarts the window count after a match while
      // the shift register keeps running.
      if (hit_c && !OVERLAP) begin
        fill <= '0;
      end else begin
        fill <= fill_inc_c;
      end
    end
  end

  // One-cycle match pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      ww <= 1'b0;
    end else begin
      ww <= hit_c;
    end
  end

  // Saturating match counter; clear beats a simultaneous hit.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (hit_c && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//   Three detector instances share one stimulus stream:
//     u0 : defaults (PAT_LEN=3, 101, OVERLAP=1, CNT_W=8)
//     u1 : OVERLAP=0
//     u2 : CNT_W=2 (counter saturates at 3)
//   Directed vectors from a table, hand-written reset/corner sequences, then
//   random traffic compared against a bit-history reference model.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       aa = 1'b0;
  logic       pat_load = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [2:0] pat_in = 3'b000;

  logic       ww0, ww1, ww2;
  logic [2:0] pat0, pat1, pat2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  always #5 clock = ~clock;

  seq_detector_param u0 (
    .clock(clock), .rst(rst), .en(en), .aa(aa), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .ww(ww0), .pattern(pat0),
    .match_cnt(cnt0));

  seq_detector_param #(.OVERLAP(1'b0)) u1 (
    .clock(clock), .rst(rst), .en(en), .aa(aa), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .ww(ww1), .pattern(pat1),
    .match_cnt(cnt1));

  seq_detector_param #(.CNT_W(2)) u2 (
    .clock(clock), .rst(rst), .en(en), .aa(aa), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .ww(ww2), .pattern(pat2),
    .match_cnt(cnt2));

  int nvec = 0;
  int nerr = 0;

  // Reference model: list of bits received since the last reset/load (or
  // since the last match when overlap is off), compared as a whole window.
  bit         hist [3][$];
  int         cnt_m [3];
  bit         ww_m [3];
  logic [2:0] pat_m;
  int         cmax_m [3] = '{255, 255, 3};
  bit         ovl_m [3]  = '{1'b1, 1'b0, 1'b1};

  typedef struct {
    logic       en;
    logic       aa;
    logic       ld;
    logic [2:0] pin;
    logic       clr;
    logic [2:0] ew;    // bit i = expected ww of instance i
    int         ec0;
    int         ec1;
    int         ec2;
    logic [2:0] epat;
  } vec_t;

  vec_t tbl [$];

  task automatic add_row(input logic e, input logic a, input logic l,
                         input logic [2:0] pi, input logic c,
                         input logic [2:0] ew, input int e0, input int e1,
                         input int e2, input logic [2:0] ep);
    vec_t v;
    v.en = e; v.aa = a; v.ld = l; v.pin = pi; v.clr = c;
    v.ew = ew; v.ec0 = e0; v.ec1 = e1; v.ec2 = e2; v.epat = ep;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void get(input int i, output int w, output int c,
                              output int p);
    case (i)
      0:       begin w = int'(ww0); c = int'(cnt0); p = int'(pat0); end
      1:       begin w = int'(ww1); c = int'(cnt1); p = int'(pat1); end
      default: begin w = int'(ww2); c = int'(cnt2); p = int'(pat2); end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i].delete();
      cnt_m[i] = 0;
      ww_m[i]  = 1'b0;
    end
    pat_m = 3'b101;
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (pat_load) begin
        hist[i].delete();
        ww_m[i] = 1'b0;
      end else if (en) begin
        hist[i].push_back(aa);
        if (hist[i].size() > 3) void'(hist[i].pop_front());
        ww_m[i] = (hist[i].size() == 3) &&
                  ({hist[i][0], hist[i][1], hist[i][2]} == pat_m);
        if (ww_m[i]) begin
          if (!ovl_m[i]) hist[i].delete();
          if (cnt_m[i] < cmax_m[i]) cnt_m[i]++;
        end
      end else begin
        ww_m[i] = 1'b0;
      end
      if (cnt_clr) cnt_m[i] = 0;
    end
    if (pat_load) pat_m = pat_in;
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after rising.
  task automatic cycle(input logic e, input logic a, input logic l,
                       input logic [2:0] pi, input logic c);
    @(negedge clock);
    en = e; aa = a; pat_load = l; pat_in = pi; cnt_clr = c;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic check_const(input string tag, input int w, input int c,
                             input int p);
    int aw, ac, ap;
    for (int i = 0; i < 3; i++) begin
      get(i, aw, ac, ap);
      chk($sformatf("%s u%0d ww", tag, i), aw, w);
      chk($sformatf("%s u%0d cnt", tag, i), ac, c);
      chk($sformatf("%s u%0d pattern", tag, i), ap, p);
    end
  endtask

  task automatic check_model(input string tag);
    int aw, ac, ap;
    for (int i = 0; i < 3; i++) begin
      get(i, aw, ac, ap);
      chk($sformatf("%s u%0d ww", tag, i), aw, int'(ww_m[i]));
      chk($sformatf("%s u%0d cnt", tag, i), ac, cnt_m[i]);
      chk($sformatf("%s u%0d pattern", tag, i), ap, int'(pat_m));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw, ac, ap;
    int ec [3];

    // Directed table: en, aa, ld, pin, clr | ww(u2,u1,u0), cnt u0,u1,u2, pattern
    add_row(1, 1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b101);
    add_row(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b101);
    add_row(1, 1, 0, 3'b000, 0, 3'b111, 1, 1, 1, 3'b101);
    add_row(1, 0, 0, 3'b000, 0, 3'b000, 1, 1, 1, 3'b101);
    add_row(1, 1, 0, 3'b000, 0, 3'b101, 2, 1, 2, 3'b101);
    add_row(1, 0, 0, 3'b000, 0, 3'b000, 2, 1, 2, 3'b101);
    add_row(1, 1, 0, 3'b000, 0, 3'b111, 3, 2, 3, 3'b101);
    add_row(1, 0, 0, 3'b000, 0, 3'b000, 3, 2, 3, 3'b101);
    add_row(1, 1, 0, 3'b000, 0, 3'b101, 4, 2, 3, 3'b101);
    add_row(1, 0, 0, 3'b000, 0, 3'b000, 4, 2, 3, 3'b101);
    add_row(1, 1, 0, 3'b000, 1, 3'b111, 0, 0, 0, 3'b101);
    add_row(1, 0, 1, 3'b101, 0, 3'b000, 0, 0, 0, 3'b101);
    add_row(1, 1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b101);
    add_row(1, 0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b101);
    for (int k = 0; k < 4; k++)
      add_row(0, 1, 0, 3'b000, 0, 3'b000, 0, 0, 0, 3'b101);
    add_row(1, 1, 0, 3'b000, 0, 3'b111, 1, 1, 1, 3'b101);
    add_row(1, 1, 0, 3'b000, 0, 3'b000, 1, 1, 1, 3'b101);
    add_row(1, 0, 0, 3'b000, 0, 3'b000, 1, 1, 1, 3'b101);
    add_row(1, 1, 1, 3'b110, 0, 3'b000, 1, 1, 1, 3'b110);
    add_row(1, 1, 0, 3'b000, 0, 3'b000, 1, 1, 1, 3'b110);
    add_row(1, 1, 0, 3'b000, 0, 3'b000, 1, 1, 1, 3'b110);
    add_row(1, 0, 0, 3'b000, 0, 3'b111, 2, 2, 2, 3'b110);
    add_row(1, 1, 0, 3'b000, 0, 3'b000, 2, 2, 2, 3'b110);
    add_row(1, 0, 0, 3'b000, 0, 3'b000, 2, 2, 2, 3'b110);
    add_row(1, 1, 0, 3'b000, 0, 3'b000, 2, 2, 2, 3'b110);

    // Reset state.
    model_reset();
    #12;
    check_const("reset", 0, 0, 5);
    @(negedge clock);
    rst = 1'b1;

    foreach (tbl[r]) begin
      cycle(tbl[r].en, tbl[r].aa, tbl[r].ld, tbl[r].pin, tbl[r].clr);
      ec[0] = tbl[r].ec0; ec[1] = tbl[r].ec1; ec[2] = tbl[r].ec2;
      for (int i = 0; i < 3; i++) begin
        get(i, aw, ac, ap);
        chk($sformatf("row%0d u%0d ww", r, i), aw, int'(tbl[r].ew[i]));
        chk($sformatf("row%0d u%0d cnt", r, i), ac, ec[i]);
        chk($sformatf("row%0d u%0d pattern", r, i), ap, int'(tbl[r].epat));
      end
    end

    // Reset asserted between edges while ww is high.
    cycle(1, 1, 0, 3'b000, 0);
    cycle(1, 1, 0, 3'b000, 0);
    cycle(1, 0, 0, 3'b000, 0);
    chk("pre-rst u0 ww", int'(ww0), 1);
    chk("pre-rst u0 cnt", int'(cnt0), 3);
    #2;
    rst = 1'b0;
    #1;
    check_const("mid-rst", 0, 0, 5);
    model_reset();
    @(negedge clock);
    rst = 1'b1; en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    cycle(1, 1, 0, 3'b000, 0);
    check_const("post-rst 1", 0, 0, 5);
    cycle(1, 0, 0, 3'b000, 0);
    check_const("post-rst 10", 0, 0, 5);
    cycle(1, 1, 0, 3'b000, 0);
    check_const("post-rst 101", 1, 1, 5);

    // All-zeros pattern needs a full window of sampled zeros.
    cycle(1, 0, 1, 3'b000, 0);
    check_const("zero ld", 0, 1, 0);
    cycle(1, 0, 0, 3'b000, 0);
    check_const("zero 0", 0, 1, 0);
    cycle(1, 0, 0, 3'b000, 0);
    check_const("zero 00", 0, 1, 0);
    cycle(1, 0, 0, 3'b000, 0);
    check_const("zero 000", 1, 2, 0);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 29) == 0));
      check_model($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
